mdu_iter: RTL and testbench
===========================

# mdu_iter

Parametrised multiply/divide unit with architectural HI/LO registers, the successor to the execute stage's inline multiplier and vendor divider IP. Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO request at a time over a valid/ready handshake. Computes division with an iterative radix-2 core and multiplication with a configurable-latency pipeline. Supports a pipeline-flush cancel that discards in-flight work without touching HI/LO. Instantiated by the execute stage, which stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO.

## Interface
- `WIDTH`, 32: operand, HI and LO width; must be ≥ 4 and even.
- `MUL_LAT`, 2: multiply latency in cycles, from acceptance edge to `done`; legal range 1..4.
- `clk` in 1: clock; all state updates on the rising edge.
- `resetn` in 1: reset, asynchronous assert, active-low; one clock, reset is asynchronous and active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; high only in IDLE.
- `req_op` in 3: opcode. 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are accepted with no effect.
- `req_src1` in WIDTH: multiplicand, dividend, or MTHI/MTLO data.
- `req_src2` in WIDTH: multiplier or divisor.
- `cancel` in 1: flush; abandon any in-flight operation and drop any concurrent request.
- `busy` out 1: MUL or DIV operation in flight (state ≠ IDLE).
- `done` out 1: one-cycle pulse; HI/LO were just written by a multiply or divide.
- `div_zero` out 1: qualifies `done`; the completed divide had a zero divisor.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- **Reset values:** state IDLE, `hi` = `lo` = 0, `done` = 0, `div_zero` = 0, `busy` = 0, `req_ready` = 1.
- **Acceptance:** a request is accepted on an edge where `req_valid && req_ready && !cancel`. Operands and opcode are latched at that edge.
- **FSM states:** IDLE, MUL, DIV, FIX.
  - IDLE → MUL on an accepted MULT/MULTU.
  - IDLE → DIV on an accepted DIV/DIVU.
  - MTHI/MTLO write `hi`/`lo` at the acceptance edge, stay in IDLE, and raise neither `done` nor `busy`.
- **MUL:**
  - Product is 2·WIDTH bits; operands are sign-extended for MULT and zero-extended for MULTU.
  - A down-counter runs MUL_LAT cycles. On the last of those edges the product is written, high half to `hi` and low half to `lo`, and the FSM returns to IDLE.
- **DIV:**
  - For DIV, operand magnitudes are taken at acceptance and the sign flags are latched.
  - Restoring radix-2: one quotient bit per cycle, MSB first, WIDTH iterations tracked by a counter of width $clog2(WIDTH+1). Then → FIX.
- **FIX (one cycle):** sign-correct and write HI/LO, then → IDLE.
  - Quotient is negative iff the operand signs differ; remainder takes the dividend's sign.
  - `lo` ← quotient, `hi` ← remainder.
- **Boundary: overflow.** DIV of −2^(WIDTH−1) by −1: `lo` = −2^(WIDTH−1) (wraps), `hi` = 0. No exception.
- **Boundary: divide by zero.** Divisor 0, for DIV and DIVU: `lo` = all ones, `hi` = `req_src1` unchanged, `div_zero` = 1 with `done`. Normal latency; the FSM does not short-circuit.
- **Cancel:**
  - Any state goes to IDLE on the next edge, with no HI/LO write and no `done`.
  - Cancel in the FIX or final MUL cycle also wins, so no write occurs.
  - A request presented with `cancel` in IDLE is not accepted, including MTHI/MTLO.
- **Reset mid-operation:** immediate return to IDLE. HI/LO clear to 0.

## Timing
- Acceptance edge is E0.
- **Multiply:** HI/LO are written at edge E(MUL_LAT). `done` is high in the cycle following that edge. `req_ready` is high in that same cycle.
- **Divide:** iteration edges are E1..E(WIDTH); FIX writes HI/LO at E(WIDTH+1). `done` and `req_ready` are high in the cycle after E(WIDTH+1). Total WIDTH+1 cycles.
- **MTHI/MTLO:** the new value is visible on `hi`/`lo` in the cycle after E0. Back-to-back acceptance is allowed.
- **Throughput:** a new request may be accepted in the same cycle `done` is high.
- **Registered outputs:** `done`, `div_zero`, `hi` and `lo` are registered. `req_ready` and `busy` are decoded from state only, never from `req_valid`.

## Structure
- **Package `mdu_pkg`:** opcode localparams (`MDU_MULT` … `MDU_MTLO`) and the FSM state enum (IDLE/MUL/DIV/FIX). Shared with the decode stage.
- **Sub-module `div_radix2`:** unsigned iterative core with start/busy/quotient/remainder. Takes WIDTH as a parameter and has a synchronous abort driven by `cancel`.
- **In `mdu_iter` itself:** sign handling, the multiply pipeline, HI/LO and the FSM.

## Test plan
- **Signed divide:** DIV 7 / 0xFFFFFFFE (−2) → `lo` = 0xFFFFFFFD, `hi` = 0x00000001, `done` exactly 33 cycles after acceptance.
- **Unsigned divide and divide by zero:**
  - DIVU 0xFFFFFFFF / 0x10 → `lo` = 0x0FFFFFFF, `hi` = 0xF.
  - DIV 5 / 0 → `lo` = 0xFFFFFFFF, `hi` = 5, `div_zero` = 1.
- **Multiply:**
  - MULT 0xFFFFFFFF × 2 → `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFFE.
  - MULTU same operands → `hi` = 0x00000001, `lo` = 0xFFFFFFFE.
  - `done` arrives 2 cycles after acceptance; repeat with MUL_LAT = 1 and 4.
- **Overflow and register moves:**
  - DIV 0x80000000 / 0xFFFFFFFF → `lo` = 0x80000000, `hi` = 0.
  - MTHI 0x1234 followed next cycle by MTLO 0x5678 → `hi` = 0x1234, `lo` = 0x5678, `done` never asserted.
- **Cancel:**
  - Cancel on cycle 10 of a DIV → HI/LO unchanged, no `done`, `req_ready` = 1 next cycle.
  - Cancel in the FIX cycle → no write.
  - `req_valid` + `cancel` with MTLO → not accepted.
- **Reset mid-operation:** deassert `resetn` mid-DIV → `hi` = `lo` = 0, `busy` = 0 immediately, without waiting for a clock edge. After release, a DIVU 100 / 7 gives `lo` = 14, `hi` = 2.

Source files
------------

// File: rtl/mdu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : mdu_pkg
// Purpose  : Opcodes and FSM state encoding shared by the MDU and decode.
// Revision : 1.0
// ---------------------------------------------------------------------------
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_t;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_iter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : mdu_iter_if
// Purpose  : Request/response bundle between the execute stage and the MDU.
// Revision : 1.0
// ---------------------------------------------------------------------------
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_src1;
  logic [WIDTH-1:0] req_src2;
  logic             cancel;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output req_valid, req_op, req_src1, req_src2, cancel,
    input  req_ready, busy, done, div_zero, hi, lo
  );

  modport slave (
    input  req_valid, req_op, req_src1, req_src2, cancel,
    output req_ready, busy, done, div_zero, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/div_radix2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : div_radix2
// Purpose  : Unsigned restoring radix-2 divider, one quotient bit per cycle.
// Revision : 1.0
// ---------------------------------------------------------------------------
module div_radix2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             last,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int c_cnt_w = $clog2(WIDTH + 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_dsr;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_qbit;

  // Partial remainder never exceeds the divisor, so WIDTH+1 bits hold the trial.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dsr};
  assign w_qbit  = ~w_diff[WIDTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
      r_quo <= '0;
      r_rem <= '0;
      r_dsr <= '0;
    end else if (abort) begin
      r_cnt <= '0;
    end else if (start) begin
      r_cnt <= c_cnt_w'(WIDTH);
      r_quo <= dividend;
      r_rem <= '0;
      r_dsr <= divisor;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
      r_quo <= {r_quo[WIDTH-2:0], w_qbit};
      r_rem <= w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    end
  end

  assign busy      = (r_cnt != '0);
  assign last      = (r_cnt == c_cnt_w'(1));
  assign quotient  = r_quo;
  assign remainder = r_rem;

endmodule
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : mdu_iter
// Purpose  : Multiply/divide unit with HI/LO, iterative divide, pipelined mul.
// Revision : 1.0
// ---------------------------------------------------------------------------
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic       clk,
  input  logic       resetn,
  mdu_iter_if.slave  bus
);

  localparam int c_mcnt_w = $clog2(MUL_LAT + 1);

  mdu_state_t          r_state;
  logic [c_mcnt_w-1:0] r_mcnt;
  logic [2*WIDTH-1:0]  r_mul_a;
  logic [2*WIDTH-1:0]  r_mul_b;
  logic                r_neg_q;
  logic                r_neg_r;
  logic                r_div_zero;
  logic [WIDTH-1:0]    r_hi;
  logic [WIDTH-1:0]    r_lo;
  logic                r_done;
  logic                r_dz;

  logic                w_accept;
  logic                w_signed;
  logic                w_s1_neg;
  logic                w_s2_neg;
  logic                w_div_start;
  logic                w_div_busy;
  logic                w_div_last;
  logic [WIDTH-1:0]    w_mag1;
  logic [WIDTH-1:0]    w_mag2;
  logic [WIDTH-1:0]    w_quo;
  logic [WIDTH-1:0]    w_rem;
  logic [WIDTH-1:0]    w_fix_q;
  logic [WIDTH-1:0]    w_fix_r;
  logic [2*WIDTH-1:0]  w_prod;
  logic [2*WIDTH-1:0]  w_mul_result;

  assign w_accept    = bus.req_valid && (r_state == ST_IDLE) && !bus.cancel;
  assign w_signed    = is_signed_op(bus.req_op);
  assign w_s1_neg    = w_signed && bus.req_src1[WIDTH-1];
  assign w_s2_neg    = w_signed && bus.req_src2[WIDTH-1];
  assign w_mag1      = w_s1_neg ? -bus.req_src1 : bus.req_src1;
  assign w_mag2      = w_s2_neg ? -bus.req_src2 : bus.req_src2;
  assign w_div_start = w_accept && ((bus.req_op == MDU_DIV) || (bus.req_op == MDU_DIVU));

  div_radix2 #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (w_div_start),
    .abort     (bus.cancel),
    .dividend  (w_mag1),
    .divisor   (w_mag2),
    .busy      (w_div_busy),
    .last      (w_div_last),
    .quotient  (w_quo),
    .remainder (w_rem)
  );

  // Operands are pre-extended to 2*WIDTH, so the truncated product is exact.
  assign w_prod = r_mul_a * r_mul_b;

  generate
    if (MUL_LAT == 1) begin : g_mul_direct
      assign w_mul_result = w_prod;
    end else begin : g_mul_pipe
      logic [2*WIDTH-1:0] r_prod;
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_prod <= '0;
        end else if (r_state == ST_MUL) begin
          r_prod <= w_prod;
        end
      end
      assign w_mul_result = r_prod;
    end
  endgenerate

  // Zero divisor: core yields all-ones quotient and |dividend| remainder;
  // restoring the dividend sign on the remainder returns the original source.
  assign w_fix_q = r_div_zero ? {WIDTH{1'b1}} : (r_neg_q ? -w_quo : w_quo);
  assign w_fix_r = r_neg_r ? -w_rem : w_rem;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_mcnt     <= '0;
      r_mul_a    <= '0;
      r_mul_b    <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_dz       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      if (bus.cancel) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_accept) begin
              case (bus.req_op)
                MDU_MULT, MDU_MULTU: begin
                  r_state <= ST_MUL;
                  r_mcnt  <= c_mcnt_w'(MUL_LAT);
                  r_mul_a <= {{WIDTH{w_s1_neg}}, bus.req_src1};
                  r_mul_b <= {{WIDTH{w_s2_neg}}, bus.req_src2};
                end
                MDU_DIV, MDU_DIVU: begin
                  r_state    <= ST_DIV;
                  r_neg_q    <= w_s1_neg ^ w_s2_neg;
                  r_neg_r    <= w_s1_neg;
                  r_div_zero <= (bus.req_src2 == '0);
                end
                MDU_MTHI: r_hi <= bus.req_src1;
                MDU_MTLO: r_lo <= bus.req_src1;
                default: ;
              endcase
            end
          end
          ST_MUL: begin
            r_mcnt <= r_mcnt - 1'b1;
            if (r_mcnt == c_mcnt_w'(1)) begin
              {r_hi, r_lo} <= w_mul_result;
              r_done       <= 1'b1;
              r_state      <= ST_IDLE;
            end
          end
          ST_DIV: begin
            if (w_div_last || !w_div_busy) begin
              r_state <= ST_FIX;
            end
          end
          ST_FIX: begin
            r_hi    <= w_fix_r;
            r_lo    <= w_fix_q;
            r_done  <= 1'b1;
            r_dz    <= r_div_zero;
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done      = r_done;
  assign bus.div_zero  = r_dz;
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_mdu_iter
// Purpose  : Self-checking bench for mdu_iter with a result scoreboard.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mdu_iter_if #(.WIDTH(W)) bus  ();
  mdu_iter_if #(.WIDTH(W)) bus1 ();
  mdu_iter_if #(.WIDTH(W)) bus4 ();

  mdu_iter #(.WIDTH(W), .MUL_LAT(2)) dut    (.clk(clk), .resetn(resetn), .bus(bus));
  mdu_iter #(.WIDTH(W), .MUL_LAT(1)) dut_l1 (.clk(clk), .resetn(resetn), .bus(bus1));
  mdu_iter #(.WIDTH(W), .MUL_LAT(4)) dut_l4 (.clk(clk), .resetn(resetn), .bus(bus4));

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic drive_idle();
    bus.req_valid  = 1'b0; bus.req_op  = 3'd0; bus.req_src1  = '0; bus.req_src2  = '0; bus.cancel  = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_op = 3'd0; bus1.req_src1 = '0; bus1.req_src2 = '0; bus1.cancel = 1'b0;
    bus4.req_valid = 1'b0; bus4.req_op = 3'd0; bus4.req_src1 = '0; bus4.req_src2 = '0; bus4.cancel = 1'b0;
  endtask

  // Called 1 time unit after a rising edge; the next edge is acceptance E0.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_src1  = a;
    bus.req_src2  = b;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = n;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.hi !== '0 || bus.lo !== '0 || bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: hi=%h lo=%h done=%b dz=%b, expected all zero", bus.hi, bus.lo, bus.done, bus.div_zero);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_status: busy=%b ready=%b, expected busy=0 ready=1", bus.busy, bus.req_ready);
    end
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_div_signed();
    int lat; bit ok; exp_t e;
    sb.push_back('{hi: 32'h0000_0001, lo: 32'hFFFF_FFFD, dz: 1'b0});
    issue(MDU_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_done(lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || lat != 33) begin
      errors++;
      $display("FAIL div_signed_latency: got %0d (seen=%0b), expected 33", lat, ok);
    end
    checks++;
    if (bus.hi !== e.hi || bus.lo !== e.lo || bus.div_zero !== e.dz) begin
      errors++;
      $display("FAIL div_signed_result: hi=%h lo=%h dz=%b, expected hi=%h lo=%h dz=%b", bus.hi, bus.lo, bus.div_zero, e.hi, e.lo, e.dz);
    end
  endtask

  task automatic test_div_unsigned_zero();
    int lat; bit ok; exp_t e;
    sb.push_back('{hi: 32'h0000_000F, lo: 32'h0FFF_FFFF, dz: 1'b0});
    issue(MDU_DIVU, 32'hFFFF_FFFF, 32'h0000_0010);
    wait_done(lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || bus.hi !== e.hi || bus.lo !== e.lo || bus.div_zero !== e.dz) begin
      errors++;
      $display("FAIL divu_result: hi=%h lo=%h dz=%b seen=%0b, expected hi=%h lo=%h dz=%b", bus.hi, bus.lo, bus.div_zero, ok, e.hi, e.lo, e.dz);
    end
    sb.push_back('{hi: 32'h0000_0005, lo: 32'hFFFF_FFFF, dz: 1'b1});
    issue(MDU_DIV, 32'd5, 32'd0);
    wait_done(lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || lat != 33) begin
      errors++;
      $display("FAIL div_zero_latency: got %0d (seen=%0b), expected 33", lat, ok);
    end
    checks++;
    if (bus.hi !== e.hi || bus.lo !== e.lo || bus.div_zero !== e.dz) begin
      errors++;
      $display("FAIL div_zero_result: hi=%h lo=%h dz=%b, expected hi=%h lo=%h dz=%b", bus.hi, bus.lo, bus.div_zero, e.hi, e.lo, e.dz);
    end
  endtask

  task automatic test_mul();
    int lat; bit ok; exp_t e;
    sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFE, dz: 1'b0});
    issue(MDU_MULT, 32'hFFFF_FFFF, 32'd2);
    wait_done(lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || lat != 2) begin
      errors++;
      $display("FAIL mult_latency: got %0d (seen=%0b), expected 2", lat, ok);
    end
    checks++;
    if (bus.hi !== e.hi || bus.lo !== e.lo || bus.div_zero !== e.dz) begin
      errors++;
      $display("FAIL mult_result: hi=%h lo=%h dz=%b, expected hi=%h lo=%h dz=%b", bus.hi, bus.lo, bus.div_zero, e.hi, e.lo, e.dz);
    end
    sb.push_back('{hi: 32'h0000_0001, lo: 32'hFFFF_FFFE, dz: 1'b0});
    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_done(lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || lat != 2 || bus.hi !== e.hi || bus.lo !== e.lo) begin
      errors++;
      $display("FAIL multu_result: hi=%h lo=%h lat=%0d, expected hi=%h lo=%h lat=2", bus.hi, bus.lo, lat, e.hi, e.lo);
    end
  endtask

  task automatic test_mul_latency();
    int lat1; int lat4; logic [W-1:0] h1, l1, h4, l4; exp_t e1, e4;
    lat1 = 0; lat4 = 0; h1 = '0; l1 = '0; h4 = '0; l4 = '0;
    sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFE, dz: 1'b0});
    sb.push_back('{hi: 32'h0000_0001, lo: 32'hFFFF_FFFE, dz: 1'b0});
    bus1.req_valid = 1'b1; bus1.req_op = MDU_MULT;  bus1.req_src1 = 32'hFFFF_FFFF; bus1.req_src2 = 32'd2;
    bus4.req_valid = 1'b1; bus4.req_op = MDU_MULTU; bus4.req_src1 = 32'hFFFF_FFFF; bus4.req_src2 = 32'd2;
    @(posedge clk);
    #1;
    bus1.req_valid = 1'b0;
    bus4.req_valid = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (bus1.done && lat1 == 0) begin lat1 = n; h1 = bus1.hi; l1 = bus1.lo; end
      if (bus4.done && lat4 == 0) begin lat4 = n; h4 = bus4.hi; l4 = bus4.lo; end
    end
    e1 = sb.pop_front();
    e4 = sb.pop_front();
    checks++;
    if (lat1 != 1 || h1 !== e1.hi || l1 !== e1.lo) begin
      errors++;
      $display("FAIL mul_lat1: lat=%0d hi=%h lo=%h, expected lat=1 hi=%h lo=%h", lat1, h1, l1, e1.hi, e1.lo);
    end
    checks++;
    if (lat4 != 4 || h4 !== e4.hi || l4 !== e4.lo) begin
      errors++;
      $display("FAIL mul_lat4: lat=%0d hi=%h lo=%h, expected lat=4 hi=%h lo=%h", lat4, h4, l4, e4.hi, e4.lo);
    end
  endtask

  task automatic test_overflow_moves();
    int lat; bit ok; exp_t e; bit dseen; bit bseen;
    sb.push_back('{hi: 32'h0000_0000, lo: 32'h8000_0000, dz: 1'b0});
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || lat != 33 || bus.hi !== e.hi || bus.lo !== e.lo || bus.div_zero !== e.dz) begin
      errors++;
      $display("FAIL div_overflow: hi=%h lo=%h lat=%0d, expected hi=%h lo=%h lat=33", bus.hi, bus.lo, lat, e.hi, e.lo);
    end
    dseen = 1'b0; bseen = 1'b0;
    bus.req_valid = 1'b1; bus.req_op = MDU_MTHI; bus.req_src1 = 32'h0000_1234;
    @(posedge clk);
    #1;
    dseen |= bus.done; bseen |= bus.busy;
    checks++;
    if (bus.hi !== 32'h0000_1234) begin
      errors++;
      $display("FAIL mthi_visible: hi=%h, expected 00001234", bus.hi);
    end
    bus.req_op = MDU_MTLO; bus.req_src1 = 32'h0000_5678;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    dseen |= bus.done; bseen |= bus.busy;
    checks++;
    if (bus.hi !== 32'h0000_1234 || bus.lo !== 32'h0000_5678) begin
      errors++;
      $display("FAIL mt_moves: hi=%h lo=%h, expected hi=00001234 lo=00005678", bus.hi, bus.lo);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      dseen |= bus.done; bseen |= bus.busy;
    end
    checks++;
    if (dseen || bseen) begin
      errors++;
      $display("FAIL mt_no_done: done_seen=%0b busy_seen=%0b, expected 0 0", dseen, bseen);
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit ok; exp_t e;
    sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFF4, dz: 1'b0});
    issue(MDU_MULT, 32'd3, 32'hFFFF_FFFC);
    wait_done(lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || bus.req_ready !== 1'b1 || bus.hi !== e.hi || bus.lo !== e.lo) begin
      errors++;
      $display("FAIL b2b_first: ready=%b hi=%h lo=%h, expected ready=1 hi=%h lo=%h", bus.req_ready, bus.hi, bus.lo, e.hi, e.lo);
    end
    sb.push_back('{hi: 32'd2, lo: 32'd14, dz: 1'b0});
    issue(MDU_DIVU, 32'd100, 32'd7);
    wait_done(lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || lat != 33 || bus.hi !== e.hi || bus.lo !== e.lo) begin
      errors++;
      $display("FAIL b2b_second: hi=%h lo=%h lat=%0d, expected hi=%h lo=%h lat=33", bus.hi, bus.lo, lat, e.hi, e.lo);
    end
  endtask

  task automatic test_cancel();
    bit dseen;
    issue(MDU_MTHI, 32'hA5A5_A5A5, 32'd0);
    issue(MDU_MTLO, 32'h5A5A_5A5A, 32'd0);
    issue(MDU_DIV, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    bus.cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.cancel = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.hi !== 32'hA5A5_A5A5 || bus.lo !== 32'h5A5A_5A5A) begin
      errors++;
      $display("FAIL cancel_mid_div: ready=%b busy=%b hi=%h lo=%h, expected 1 0 a5a5a5a5 5a5a5a5a", bus.req_ready, bus.busy, bus.hi, bus.lo);
    end
    dseen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      dseen |= bus.done;
    end
    checks++;
    if (dseen || bus.hi !== 32'hA5A5_A5A5 || bus.lo !== 32'h5A5A_5A5A) begin
      errors++;
      $display("FAIL cancel_no_done: done_seen=%0b hi=%h lo=%h, expected 0 a5a5a5a5 5a5a5a5a", dseen, bus.hi, bus.lo);
    end
    issue(MDU_DIVU, 32'd100, 32'd7);
    repeat (32) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL fix_busy: busy=%b, expected 1", bus.busy);
    end
    bus.cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.cancel = 1'b0;
    dseen = bus.done;
    repeat (5) begin
      @(posedge clk);
      #1;
      dseen |= bus.done;
    end
    checks++;
    if (dseen || bus.hi !== 32'hA5A5_A5A5 || bus.lo !== 32'h5A5A_5A5A) begin
      errors++;
      $display("FAIL cancel_fix: done_seen=%0b hi=%h lo=%h, expected 0 a5a5a5a5 5a5a5a5a", dseen, bus.hi, bus.lo);
    end
    bus.req_valid = 1'b1; bus.req_op = MDU_MTLO; bus.req_src1 = 32'hDEAD_BEEF; bus.cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0; bus.cancel = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.lo !== 32'h5A5A_5A5A) begin
      errors++;
      $display("FAIL cancel_mtlo: lo=%h, expected 5a5a5a5a", bus.lo);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat; bit ok; exp_t e;
    issue(MDU_DIVU, 32'hFFFF_FFFF, 32'd3);
    repeat (5) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    checks++;
    if (bus.hi !== '0 || bus.lo !== '0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: hi=%h lo=%h busy=%b ready=%b, expected 0 0 0 1", bus.hi, bus.lo, bus.busy, bus.req_ready);
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{hi: 32'd2, lo: 32'd14, dz: 1'b0});
    issue(MDU_DIVU, 32'd100, 32'd7);
    wait_done(lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || bus.hi !== e.hi || bus.lo !== e.lo || bus.div_zero !== e.dz) begin
      errors++;
      $display("FAIL reset_recover: hi=%h lo=%h seen=%0b, expected hi=%h lo=%h", bus.hi, bus.lo, ok, e.hi, e.lo);
    end
  endtask

  initial begin
    test_reset();
    test_div_signed();
    test_div_unsigned_zero();
    test_mul();
    test_mul_latency();
    test_overflow_moves();
    test_back_to_back();
    test_cancel();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
